// File: rtl/muldiv_pkg.sv
// Shared types and ALU control codes for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;

endpackage

// File: rtl/module_alu.sv
// Team 32-bit combinational ALU; the sequencer only uses add and subtract.
module module_alu
  import muldiv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLTU: result_o = {31'b0, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/module_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider (MUL, DIVU, REMU) built
// around one shared ALU; fixed latency, one iteration per clock.
module module_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dato1_i,
  input  logic [WIDTH-1:0] dato2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(ITER + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // a: accumulator (MUL) / remainder low word (DIV)
  // b: multiplicand (MUL) / divisor (DIV)
  // c: multiplier (MUL) / dividend shifting into quotient (DIV)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [2:0]       alu_ctrl;
  logic             unused_alu_zero;

  // The top remainder bit only lives for one cycle between shift and compare,
  // since a restored remainder is always below the divisor.
  logic             rhi_s;
  logic [WIDTH-1:0] rlo_s;
  logic             sub_ok;

  assign rhi_s  = a_q[WIDTH-1];
  assign rlo_s  = {a_q[WIDTH-2:0], c_q[WIDTH-1]};
  assign sub_ok = rhi_s | (rlo_s >= b_q);

  module_alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_res),
    .zero_o   (unused_alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    done_d   = 1'b0;
    result_d = result_q;
    alu_a    = a_q;
    alu_b    = b_q;
    alu_ctrl = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          op_d    = op_e'(op_i);
          cnt_d   = '0;
          a_d     = '0;
          if (op_e'(op_i) == OP_MUL) begin
            b_d = dato1_i;
            c_d = dato2_i;
          end else begin
            b_d = dato2_i;
            c_d = dato1_i;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = S_DONE;
        end
        case (op_q)
          OP_MUL: begin
            if (c_q[0]) begin
              a_d = alu_res;
            end
            b_d = b_q << 1;
            c_d = c_q >> 1;
          end
          OP_DIVU, OP_REMU: begin
            alu_a    = rlo_s;
            alu_ctrl = ALU_SUB;
            a_d      = sub_ok ? alu_res : rlo_s;
            c_d      = {c_q[WIDTH-2:0], sub_ok};
          end
          default: ;
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MUL:  result_d = a_q;
          OP_DIVU: result_d = c_q;
          OP_REMU: result_d = a_q;
          default: result_d = '0;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_module_muldiv_seq.sv
// Scoreboard bench for module_muldiv_seq: the driver queues expected results and
// done cycles, a negedge monitor pops and checks on every done_o pulse.
module tb_module_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  module_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .dato1_i  (d1),
    .dato2_i  (d2),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done_o at cycle %0d with empty scoreboard", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called just after a negedge; returns 1ns after the accepting edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    start = 1'b1;
    op    = o;
    d1    = a;
    d2    = b;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{res: exp, cyc: cyc + 33, name: name});
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_n, output int done_cyc);
    bit ok;
    ok       = 1'b0;
    busy_n   = 0;
    done_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok       = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (busy) busy_n++;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: no done_o within 100 cycles, expected one", name);
    end
  endtask

  initial begin
    int bn, dc1, dc2;

    #12;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
    wait_done("mul_7x6", bn, dc1);
    check("mul_7x6_busy_cycles", 32'(bn), 32'd33);
    check("busy_low_in_done_cycle", {31'b0, busy}, 32'h0);

    issue("mul_ffff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    wait_done("mul_ffff", bn, dc1);
    issue("mul_ovf", 2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    wait_done("mul_ovf", bn, dc1);
    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000000E, 1'b1);
    wait_done("divu_100_7", bn, dc1);
    issue("remu_100_7", 2'b10, 32'd100, 32'd7, 32'h00000002, 1'b1);
    wait_done("remu_100_7", bn, dc1);
    issue("divu_big", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done("divu_big", bn, dc1);
    issue("remu_big", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    wait_done("remu_big", bn, dc1);
    issue("divu_by0", 2'b01, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1);
    wait_done("divu_by0", bn, dc1);
    issue("remu_by0", 2'b10, 32'h12345678, 32'h0, 32'h12345678, 1'b1);
    wait_done("remu_by0", bn, dc1);
    issue("rsvd", 2'b11, 32'hDEADBEEF, 32'h1234, 32'h00000000, 1'b1);
    wait_done("rsvd", bn, dc1);

    // start_i during RUN (cnt=10) with new operands must be ignored.
    issue("divu_ignore", 2'b01, 32'd100, 32'd7, 32'h0000000E, 1'b1);
    repeat (11) @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    d1    = 32'd1;
    d2    = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("divu_ignore", bn, dc1);

    // Back-to-back: second start in the cycle right after DONE.
    issue("b2b_mul", 2'b00, 32'h00001234, 32'h00000010, 32'h00012340, 1'b1);
    wait_done("b2b_mul", bn, dc1);
    issue("b2b_remu", 2'b10, 32'd1000, 32'd37, 32'h00000001, 1'b1);
    wait_done("b2b_remu", bn, dc2);
    check("b2b_done_spacing", 32'(dc2 - dc1), 32'd34);

    // Reset at cnt=15 aborts the operation without a done_o pulse.
    issue("aborted", 2'b00, 32'd9, 32'd9, 32'd81, 1'b0);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_result", result, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_result", result, 32'h0);
    issue("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 1'b1);
    wait_done("mul_3x5", bn, dc1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
